// File: rtl/vga_pkg.sv
// Shared VGA raster definitions.
// Holds the pixel/coordinate types and the 640x480@60 timing constants used by
// the scan/fetch block, the colour mapper and the game logic, plus a small
// range-test helper used by the timing decode.
package vga_pkg;

    typedef logic [4:0] color_idx_t;
    typedef logic [9:0] coord_t;

    // Horizontal timing, in pixels
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Board window placement and frame-memory geometry
    localparam int WIN_X0  = 193;
    localparam int WIN_Y0  = 120;
    localparam int WIN_W   = 254;
    localparam int WIN_H   = 239;
    localparam int ADDR_W  = 16;
    localparam int RD_LAT  = 2;

    // lo <= v < hi, evaluated in int so the bounds may be any timing constant
    function automatic logic in_range(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_scan_fetch_if.sv
// Frame-memory read port of the raster source.
//   rd    : read strobe (scanner -> memory)
//   addr  : window-relative word address (scanner -> memory)
//   rdata : palette index, valid RD_LAT cycles after the strobe (memory -> scanner)
// master = scanner side, slave = memory side.
interface vga_scan_fetch_if #(
    parameter int ADDR_W = 16
) ();
    import vga_pkg::*;

    logic              rd;
    logic [ADDR_W-1:0] addr;
    color_idx_t        rdata;

    modport master (output rd, output addr, input rdata);
    modport slave  (input rd, input addr, output rdata);

endinterface

// File: rtl/vga_delay_line.sv
// Generic clearable shift register.
//   Clk, Reset_n : clock, asynchronous active-low clear of every stage
//   d_i          : input word
//   q_o          : d_i delayed by DEPTH cycles
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_fetch.sv
// Raster source: VGA timing counters, board-window frame-memory fetch and the
// alignment pipeline that lines the fetched palette index up with DrawX/DrawY.
//   Clk, Reset_n  : pixel clock, asynchronous active-low reset
//   fb            : frame-memory read port (rd/addr out, rdata in)
//   color         : palette index for the output pixel (0 outside the window)
//   DrawX, DrawY  : output pixel coordinates
//   VGA_HS/VS     : syncs, active low
//   VGA_BLANK_N   : 1 inside the visible area
//   frame_start   : one-cycle pulse when the counters wrap to (0,0), undelayed
module vga_scan_fetch
    import vga_pkg::*;
#(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP,
    parameter int WIN_X0 = vga_pkg::WIN_X0,
    parameter int WIN_Y0 = vga_pkg::WIN_Y0,
    parameter int WIN_W  = vga_pkg::WIN_W,
    parameter int WIN_H  = vga_pkg::WIN_H,
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int RD_LAT = vga_pkg::RD_LAT
) (
    input  logic              Clk,
    input  logic              Reset_n,
    vga_scan_fetch_if.master  fb,
    output color_idx_t        color,
    output coord_t            DrawX,
    output coord_t            DrawY,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    // {h, v, hs_act, vs_act, vis, win}
    localparam int PIPE_W = 2 * $bits(coord_t) + 4;

    coord_t            h_cnt_q, h_cnt_d;
    coord_t            v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              started_q;

    logic end_of_line, end_of_frame;
    logic win_row, win_col, win0, hs_act0, vs_act0, vis0;

    logic [PIPE_W-1:0] pipe_in, pipe_rl;
    logic [PIPE_W-2:0] out_q;
    color_idx_t        color_q;
    logic              hs_act_out, vs_act_out;

    // Stage-0 decode straight from the counter registers
    assign end_of_line  = (int'(h_cnt_q) == H_TOT - 1);
    assign end_of_frame = (int'(v_cnt_q) == V_TOT - 1);
    assign win_row      = in_range(v_cnt_q, WIN_Y0, WIN_Y0 + WIN_H);
    assign win_col      = in_range(h_cnt_q, WIN_X0, WIN_X0 + WIN_W);
    assign win0         = win_row && win_col;
    assign hs_act0      = in_range(h_cnt_q, H_VIS + H_FP, H_VIS + H_FP + H_SYNC);
    assign vs_act0      = in_range(v_cnt_q, V_VIS + V_FP, V_VIS + V_FP + V_SYNC);
    assign vis0         = in_range(h_cnt_q, 0, H_VIS) && in_range(v_cnt_q, 0, V_VIS);

    // Row-major address built from a running line base, so no multiplier
    assign fb.rd   = win0;
    assign fb.addr = win0 ? (line_base_q + ADDR_W'(h_cnt_q - coord_t'(WIN_X0))) : '0;

    // The first cycle after reset sits at (0,0) but is not a frame wrap
    assign frame_start = started_q && (h_cnt_q == '0) && (v_cnt_q == '0);

    always_comb begin
        h_cnt_d     = end_of_line ? '0 : h_cnt_q + coord_t'(1);
        v_cnt_d     = v_cnt_q;
        line_base_d = line_base_q;
        if (end_of_line) begin
            v_cnt_d = end_of_frame ? '0 : v_cnt_q + coord_t'(1);
            if (end_of_frame) begin
                line_base_d = '0;
            end else if (win_row) begin
                line_base_d = line_base_q + ADDR_W'(WIN_W);
            end
        end
    end

    // Syncs travel as active-high flags so a cleared pipeline reads as
    // "sync inactive" and the outputs come up high during reset.
    assign pipe_in = {h_cnt_q, v_cnt_q, hs_act0, vs_act0, vis0, win0};

    // First RD_LAT stages: window flag arrives together with fb.rdata
    vga_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (RD_LAT)
    ) u_align (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d_i     (pipe_in),
        .q_o     (pipe_rl)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            line_base_q <= '0;
            started_q   <= 1'b0;
            out_q       <= '0;
            color_q     <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            line_base_q <= line_base_d;
            started_q   <= 1'b1;
            // Final stage: coordinates/syncs and the captured read word
            out_q       <= pipe_rl[PIPE_W-1:1];
            color_q     <= pipe_rl[0] ? fb.rdata : '0;
        end
    end

    assign {DrawX, DrawY, hs_act_out, vs_act_out, VGA_BLANK_N} = out_q;
    assign VGA_HS = ~hs_act_out;
    assign VGA_VS = ~vs_act_out;
    assign color  = color_q;

endmodule
